// File: rtl/btn_toggle_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_toggle_gen: debounced push-button to T-flip-flop toggle-pulse source  |
// | Optional auto-repeat when BTN_TOGGLE_AUTOREPEAT_EN is defined.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module btn_toggle_gen #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       t_out,
  output logic       btn_db,
  output logic [7:0] pulse_cnt
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES);

  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db_cycles
    $error("btn_toggle_gen: DB_CYCLES out of range 1..255");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 1023) begin : g_bad_repeat_delay
    $error("btn_toggle_gen: REPEAT_DELAY out of range 1..1023");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 1023) begin : g_bad_repeat_period
    $error("btn_toggle_gen: REPEAT_PERIOD out of range 1..1023");
  end

  logic       s1, s2;
  logic [1:0] state, state_nxt;
  logic [7:0] db_cnt, db_cnt_nxt;
  logic       t_nxt, db_nxt;
  logic       rep_fire;

  // btn_in is asynchronous; nothing downstream may look at it before s2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      db_cnt    <= 8'd0;
      t_out     <= 1'b0;
      btn_db    <= 1'b0;
      pulse_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
      t_out  <= t_nxt;
      btn_db <= db_nxt;
      if (t_nxt) begin
        pulse_cnt <= pulse_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    case (state)
      IDLE: begin
        if (s2) begin
          state_nxt  = PRESS_WAIT;
          db_cnt_nxt = 8'd1;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_nxt  = IDLE;
          db_cnt_nxt = 8'd0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = 8'd0;
        end else begin
          db_cnt_nxt = db_cnt + 8'd1;
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_nxt  = RELEASE_WAIT;
          db_cnt_nxt = 8'd1;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = 8'd0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = IDLE;
          db_cnt_nxt = 8'd0;
        end else begin
          db_cnt_nxt = db_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_comb begin
    t_nxt  = rep_fire;
    db_nxt = btn_db;
    if (state == PRESS_WAIT && s2 && db_cnt == DB_LAST) begin
      t_nxt  = 1'b1;
      db_nxt = 1'b1;
    end else if (state == RELEASE_WAIT && !s2 && db_cnt == DB_LAST) begin
      db_nxt = 1'b0;
    end
  end

`ifdef BTN_TOGGLE_AUTOREPEAT_EN
  localparam logic [9:0] DELAY_LAST  = 10'(REPEAT_DELAY - 1);
  localparam logic [9:0] PERIOD_LAST = 10'(REPEAT_PERIOD - 1);

  logic [9:0] hold_cnt;
  logic       rep_phase;
  logic       hold_tick;
  logic       rep_hit;

  // The counter only exists in PRESSED/RELEASE_WAIT, so a release bounce
  // leaves it frozen and the hold resumes where it left off.
  assign hold_tick = (state == PRESSED) && s2;
  assign rep_hit   = hold_tick && (hold_cnt == (rep_phase ? PERIOD_LAST : DELAY_LAST));
  assign rep_fire  = rep_hit && !t_out;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == PRESS_WAIT) begin
      hold_cnt  <= 10'd0;
      rep_phase <= 1'b0;
    end else if (rep_hit) begin
      hold_cnt  <= 10'd0;
      rep_phase <= 1'b1;
    end else if (hold_tick) begin
      hold_cnt  <= hold_cnt + 10'd1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule
`default_nettype wire
